rename_stage: RTL and testbench

RENAME_STAGE -- requirements
Module: rename_stage

---
 rtl/rename_stage.sv | 173 +++++++++++++++++
 tb/tb_rename_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
// Register rename stage: maps architectural sources/destinations of a
// WIDTH-wide decode group onto physical tags through a 32-entry alias table,
// with in-group RAW/WAW forwarding and a one-cycle registered result.

package rename_pkg;

    localparam int unsigned AREG_W = 5;
    localparam int unsigned PTAG_W = 7;

    // Opaque instruction fields carried alongside the rename result
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } payload_t;

    // One decoded instruction slot
    typedef struct packed {
        logic              valid;
        logic [AREG_W-1:0] rs1;
        logic [AREG_W-1:0] rs2;
        logic [AREG_W-1:0] rd;
        logic              uses_rs1;
        logic              uses_rs2;
        logic              writes_rd;
        payload_t          payload;
    } decode_t;

    // One renamed instruction slot
    typedef struct packed {
        logic              valid;
        logic [PTAG_W-1:0] prs1;
        logic [PTAG_W-1:0] prs2;
        logic [PTAG_W-1:0] prd;
        logic [PTAG_W-1:0] old_prd;
        logic [AREG_W-1:0] rd;
        payload_t          payload;
    } rename_t;

endpackage

module rename_stage
    import rename_pkg::*;
#(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned PREG_W = rename_pkg::PTAG_W
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [WIDTH-1:0][PREG_W-1:0]  i_free_PRegs,
    input  decode_t [WIDTH-1:0]           i_decode_data,
    output rename_t [WIDTH-1:0]           o_rename_data,
    output logic [WIDTH-1:0]              o_alloc
);

    localparam int unsigned NUM_AREGS = 32;

    // Alias table: architectural register -> current physical tag
    logic [PREG_W-1:0] rat_q [NUM_AREGS];
    logic [PREG_W-1:0] rat_d [NUM_AREGS];

    // Registered rename group
    rename_t [WIDTH-1:0] out_q;
    rename_t [WIDTH-1:0] out_d;

    // Per-slot combinational results
    logic [WIDTH-1:0]             alloc_c;
    logic [WIDTH-1:0][PREG_W-1:0] prd_c;
    logic [WIDTH-1:0][PREG_W-1:0] prs1_c;
    logic [WIDTH-1:0][PREG_W-1:0] prs2_c;
    logic [WIDTH-1:0][PREG_W-1:0] old_prd_c;

    // Allocation decision: a valid slot that writes a non-zero rd takes its free tag
    always_comb begin : alloc_decode
        alloc_c = '0;
        prd_c   = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            alloc_c[k] = i_decode_data[k].valid
                      && i_decode_data[k].writes_rd
                      && (i_decode_data[k].rd != '0);
            if (alloc_c[k]) begin
                prd_c[k] = i_free_PRegs[k];
            end
        end
    end

    // Allocation handshake is combinational and suppressed while in reset
    assign o_alloc = i_rst ? '0 : alloc_c;

    // Source and previous-destination lookup with forwarding from older slots
    always_comb begin : tag_lookup
        logic [PREG_W-1:0] src1;
        logic [PREG_W-1:0] src2;
        logic [PREG_W-1:0] prev;
        prs1_c    = '0;
        prs2_c    = '0;
        old_prd_c = '0;
        src1      = '0;
        src2      = '0;
        prev      = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            src1 = rat_q[i_decode_data[k].rs1];
            src2 = rat_q[i_decode_data[k].rs2];
            prev = rat_q[i_decode_data[k].rd];
            // Later older slots override earlier ones, so the youngest older writer wins
            for (int unsigned j = 0; j < k; j++) begin
                if (alloc_c[j] && (i_decode_data[j].rd == i_decode_data[k].rs1)) begin
                    src1 = prd_c[j];
                end
                if (alloc_c[j] && (i_decode_data[j].rd == i_decode_data[k].rs2)) begin
                    src2 = prd_c[j];
                end
                if (alloc_c[j] && (i_decode_data[j].rd == i_decode_data[k].rd)) begin
                    prev = prd_c[j];
                end
            end
            // x0 and unused sources always read tag 0
            if (i_decode_data[k].valid && i_decode_data[k].uses_rs1
                    && (i_decode_data[k].rs1 != '0)) begin
                prs1_c[k] = src1;
            end
            if (i_decode_data[k].valid && i_decode_data[k].uses_rs2
                    && (i_decode_data[k].rs2 != '0)) begin
                prs2_c[k] = src2;
            end
            if (alloc_c[k]) begin
                old_prd_c[k] = prev;
            end
        end
    end

    // Assemble the next output record; rd and payload pass through untouched
    always_comb begin : out_build
        out_d = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            out_d[k].valid   = i_decode_data[k].valid;
            out_d[k].prs1    = PTAG_W'(prs1_c[k]);
            out_d[k].prs2    = PTAG_W'(prs2_c[k]);
            out_d[k].prd     = PTAG_W'(prd_c[k]);
            out_d[k].old_prd = PTAG_W'(old_prd_c[k]);
            out_d[k].rd      = i_decode_data[k].rd;
            out_d[k].payload = i_decode_data[k].payload;
        end
    end

    // Table update in slot order so the youngest writer of an rd lands last
    always_comb begin : rat_update
        rat_d = rat_q;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (alloc_c[k]) begin
                rat_d[i_decode_data[k].rd] = prd_c[k];
            end
        end
        rat_d[0] = '0;
    end

    // State registers; reset restores the identity mapping and clears the output
    always_ff @(posedge i_clk) begin : state_regs
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_AREGS; i++) begin
                rat_q[i] <= PREG_W'(i);
            end
            out_q <= '0;
        end else begin
            rat_q <= rat_d;
            out_q <= out_d;
        end
    end

    assign o_rename_data = out_q;

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: table of per-cycle vectors feeding a
// scoreboard of expected rename records, plus a hand-written reset sequence.

module tb_rename_stage;
    import rename_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned PW = 7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [W-1:0][PW-1:0]    free_tags;
    decode_t [W-1:0]         dec;
    rename_t [W-1:0]         ren;
    logic [W-1:0]            alloc;

    always #5 clk = ~clk;

    rename_stage #(.WIDTH(W), .PREG_W(PW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_free_PRegs  (free_tags),
        .i_decode_data (dec),
        .o_rename_data (ren),
        .o_alloc       (alloc)
    );

    typedef struct {
        string                name;
        logic                 rst;
        decode_t [W-1:0]      dec;
        logic [W-1:0][PW-1:0] free;
        logic [W-1:0]         exp_alloc;
        rename_t [W-1:0]      exp_ren;
    } vec_t;

    typedef struct {
        string           name;
        rename_t [W-1:0] ren;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic decode_t mk_dec(bit v, int rd, int rs1, int rs2,
                                       bit u1, bit u2, bit wr, int tag);
        decode_t d;
        d                = '0;
        d.valid          = v;
        d.rd             = 5'(rd);
        d.rs1            = 5'(rs1);
        d.rs2            = 5'(rs2);
        d.uses_rs1       = u1;
        d.uses_rs2       = u2;
        d.writes_rd      = wr;
        d.payload.opcode = 7'(tag + 3);
        d.payload.funct3 = 3'(tag);
        d.payload.funct7 = 7'(tag >> 2);
        d.payload.imm    = 32'(tag * 1001 + 7);
        return d;
    endfunction

    function automatic decode_t add(bit v, int rd, int rs1, int rs2, int tag);
        return mk_dec(v, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, tag);
    endfunction

    function automatic rename_t mk_ren(bit v, int prs1, int prs2, int prd, int old_prd,
                                       decode_t d);
        rename_t r;
        r         = '0;
        r.valid   = v;
        r.prs1    = 7'(prs1);
        r.prs2    = 7'(prs2);
        r.prd     = 7'(prd);
        r.old_prd = 7'(old_prd);
        r.rd      = d.rd;
        r.payload = d.payload;
        return r;
    endfunction

    function automatic vec_t mk_vec(string name, logic r, decode_t d0, decode_t d1,
                                    int f0, int f1, logic [W-1:0] ea,
                                    rename_t e0, rename_t e1);
        vec_t v;
        v.name       = name;
        v.rst        = r;
        v.dec[0]     = d0;
        v.dec[1]     = d1;
        v.free[0]    = 7'(f0);
        v.free[1]    = 7'(f1);
        v.exp_alloc  = ea;
        v.exp_ren[0] = e0;
        v.exp_ren[1] = e1;
        return v;
    endfunction

    // Compare the registered output against the oldest scoreboard entry
    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got no expected entry, want one");
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < W; k++) begin
                n_vec++;
                if (ren[k] !== e.ren[k]) begin
                    n_err++;
                    $display("FAIL %s slot%0d: got %h, want %h", e.name, k, ren[k], e.ren[k]);
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, check o_alloc, then check the registered result
    task automatic apply(input vec_t v);
        exp_t e;
        rst       = v.rst;
        dec       = v.dec;
        free_tags = v.free;
        #1;
        n_vec++;
        if (alloc !== v.exp_alloc) begin
            n_err++;
            $display("FAIL %s alloc: got %b, want %b", v.name, alloc, v.exp_alloc);
        end
        e.name = v.name;
        e.ren  = v.exp_ren;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        decode_t a, b;
        rename_t z;
        z         = '0;
        rst       = 1'b1;
        dec       = '0;
        free_tags = '0;

        // Reset with live-looking inputs: outputs and alloc must stay zero
        a = add(1, 3, 1, 2, 1); b = add(1, 7, 3, 3, 2);
        tbl.push_back(mk_vec("rst0", 1'b1, a, b, 99, 98, 2'b00, z, z));
        tbl.push_back(mk_vec("rst1", 1'b1, a, b, 99, 98, 2'b00, z, z));
        // add x3,x1,x2 from the identity table
        a = add(1, 3, 1, 2, 3); b = add(0, 4, 1, 1, 4);
        tbl.push_back(mk_vec("reset_read", 1'b0, a, b, 40, 41, 2'b01,
                             mk_ren(1, 1, 2, 40, 3, a), mk_ren(0, 0, 0, 0, 0, b)));
        // RAW: slot 1 reads slot 0's new x5
        a = add(1, 5, 3, 4, 5); b = add(1, 8, 5, 6, 6);
        tbl.push_back(mk_vec("raw_bypass", 1'b0, a, b, 50, 51, 2'b11,
                             mk_ren(1, 40, 4, 50, 5, a), mk_ren(1, 50, 6, 51, 8, b)));
        // WAW: both write x7, slot 1 also reads x7
        a = add(1, 7, 5, 8, 7); b = add(1, 7, 7, 1, 8);
        tbl.push_back(mk_vec("waw_group", 1'b0, a, b, 60, 61, 2'b11,
                             mk_ren(1, 50, 51, 60, 7, a), mk_ren(1, 60, 1, 61, 60, b)));
        // x7 now 61; slot 1 writes x0
        a = add(1, 9, 7, 0, 9); b = add(1, 0, 1, 2, 10);
        tbl.push_back(mk_vec("waw_after_x0_write", 1'b0, a, b, 62, 70, 2'b01,
                             mk_ren(1, 61, 0, 62, 9, a), mk_ren(1, 1, 2, 0, 0, b)));
        // x0 read gives 0; invalid slot 1 writing x11
        a = add(1, 10, 0, 9, 11); b = add(0, 11, 1, 2, 12);
        tbl.push_back(mk_vec("x0_read_invalid", 1'b0, a, b, 71, 72, 2'b01,
                             mk_ren(1, 0, 62, 71, 10, a), mk_ren(0, 0, 0, 0, 0, b)));
        // Store in slot 0; slot 1 reads x11 (untouched) and x12 (store rd not written)
        a = mk_dec(1, 12, 9, 10, 1'b1, 1'b1, 1'b0, 13); b = add(1, 13, 11, 12, 14);
        tbl.push_back(mk_vec("store", 1'b0, a, b, 80, 81, 2'b10,
                             mk_ren(1, 62, 71, 0, 0, a), mk_ren(1, 11, 12, 81, 13, b)));
        // Source-use flags: lui x14; slot 1 ignores rs1, reads x14 via rs2, rewrites x14
        a = mk_dec(1, 14, 5, 6, 1'b0, 1'b0, 1'b1, 15); b = mk_dec(1, 14, 14, 14, 1'b0, 1'b1, 1'b1, 16);
        tbl.push_back(mk_vec("uses_flags", 1'b0, a, b, 82, 83, 2'b11,
                             mk_ren(1, 0, 0, 82, 14, a), mk_ren(1, 0, 82, 83, 82, b)));
        // Invalid slot 0 writing x15 must not forward to slot 1
        a = add(0, 15, 1, 2, 17); b = add(1, 16, 15, 14, 18);
        tbl.push_back(mk_vec("invalid_no_bypass", 1'b0, a, b, 84, 85, 2'b10,
                             mk_ren(0, 0, 0, 0, 0, a), mk_ren(1, 15, 83, 85, 16, b)));
        // Rename x3 again (currently 40) just before a mid-stream reset
        a = add(1, 3, 1, 2, 19); b = add(0, 5, 1, 1, 20);
        tbl.push_back(mk_vec("pre_reset", 1'b0, a, b, 40, 41, 2'b01,
                             mk_ren(1, 1, 2, 40, 40, a), mk_ren(0, 0, 0, 0, 0, b)));
        a = add(1, 4, 3, 3, 21); b = add(1, 3, 4, 4, 22);
        tbl.push_back(mk_vec("mid_reset", 1'b1, a, b, 90, 91, 2'b00, z, z));
        // Identity restored; reset-cycle writes of x4/x3 ignored
        a = add(1, 20, 3, 7, 23); b = add(1, 21, 4, 0, 24);
        tbl.push_back(mk_vec("post_reset", 1'b0, a, b, 92, 93, 2'b11,
                             mk_ren(1, 3, 7, 92, 20, a), mk_ren(1, 4, 0, 93, 21, b)));
        // Duplicate free tags are used as given
        a = add(1, 22, 1, 1, 25); b = add(1, 23, 22, 1, 26);
        tbl.push_back(mk_vec("dup_free", 1'b0, a, b, 5, 5, 2'b11,
                             mk_ren(1, 1, 1, 5, 22, a), mk_ren(1, 5, 1, 5, 23, b)));
        a = add(1, 24, 22, 23, 27); b = add(1, 25, 0, 0, 28);
        tbl.push_back(mk_vec("dup_readback", 1'b0, a, b, 33, 34, 2'b11,
                             mk_ren(1, 5, 5, 33, 24, a), mk_ren(1, 0, 0, 34, 25, b)));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // Hand-written: write x7, hold reset two cycles with x7 writes, read x7 back
        a = add(1, 7, 1, 1, 29); b = add(0, 2, 2, 2, 30);
        apply(mk_vec("seq_write_x7", 1'b0, a, b, 95, 94, 2'b01,
                     mk_ren(1, 1, 1, 95, 7, a), mk_ren(0, 0, 0, 0, 0, b)));
        a = add(1, 7, 7, 7, 31); b = add(1, 7, 7, 7, 32);
        apply(mk_vec("seq_rst_a", 1'b1, a, b, 96, 97, 2'b00, z, z));
        apply(mk_vec("seq_rst_b", 1'b1, a, b, 96, 97, 2'b00, z, z));
        a = add(1, 26, 7, 0, 33); b = add(0, 27, 7, 7, 34);
        apply(mk_vec("seq_read_x7", 1'b0, a, b, 98, 99, 2'b01,
                     mk_ren(1, 7, 0, 98, 26, a), mk_ren(0, 0, 0, 0, 0, b)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
